// File: rtl/pc_seq_unit.sv
// rtl/pc_seq_unit.sv - IF-stage program-counter sequencer with RAS and RUN/HALTED FSM (optional trace: PC_TRACE_EN)
module pc_seq_unit #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                INC        = 1,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              hlt,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic              call,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              ret,
    output logic [ADDR_W-1:0] iaddr,
    output logic              halted,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_iaddr;
    logic [ADDR_W-1:0]  w_iaddr_nxt;
    logic [ADDR_W-1:0]  w_seq;
    logic [ADDR_W-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   w_top_idx;
    logic [IDX_W-1:0]   w_push_idx;
    logic               r_empty;
    logic               r_full;
    logic               r_ovf;
    logic               r_unf;
    logic               w_push;
    logic               w_pop;
    logic               w_set_ovf;
    logic               w_set_unf;

    // Sequential successor wraps naturally at ADDR_W bits; it is also the pushed return address.
    assign w_seq      = r_iaddr + ADDR_W'(INC);
    assign w_top_idx  = IDX_W'(r_ptr - PTR_W'(1));
    assign w_push_idx = IDX_W'(r_ptr);

    // FSM state register; reset always returns to RUN.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Next-state and one-action-per-cycle next-address selection, stall first.
    always_comb begin
        w_state_nxt = r_state;
        w_iaddr_nxt = r_iaddr;
        w_ptr_nxt   = r_ptr;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        if (r_state == ST_RUN && !stall) begin
            if (hlt) begin
                w_state_nxt = ST_HALTED;
            end else if (ret) begin
                if (!r_empty) begin
                    w_iaddr_nxt = r_ras[w_top_idx];
                    w_pop       = 1'b1;
                    w_ptr_nxt   = r_ptr - PTR_W'(1);
                end else begin
                    w_iaddr_nxt = w_seq;
                    w_set_unf   = 1'b1;
                end
            end else if (call) begin
                w_iaddr_nxt = jmp_target;
                if (!r_full) begin
                    w_push    = 1'b1;
                    w_ptr_nxt = r_ptr + PTR_W'(1);
                end else begin
                    w_set_ovf = 1'b1;
                end
            end else if (jmp) begin
                w_iaddr_nxt = jmp_target;
            end else if (br_taken) begin
                w_iaddr_nxt = br_target;
            end else begin
                w_iaddr_nxt = w_seq;
            end
        end
    end

    // PC, stack pointer, decoded occupancy flags and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iaddr <= RESET_ADDR;
            r_ptr   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_iaddr <= w_iaddr_nxt;
            r_ptr   <= w_ptr_nxt;
            r_empty <= (w_ptr_nxt == '0);
            r_full  <= (w_ptr_nxt == PTR_W'(RAS_DEPTH));
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_unf) r_unf <= 1'b1;
        end
    end

    // Return-address storage; contents need no reset because the pointer guards them.
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_ras[w_push_idx] <= w_seq;
    end

`ifdef PC_TRACE_EN
    // Simulation trace of address changes, halt entry and new stack errors.
    always @(posedge clk) begin
        if (rst) begin
            if (r_iaddr != RESET_ADDR) $display("Instruction address = %h", RESET_ADDR);
        end else begin
            if (w_iaddr_nxt != r_iaddr) $display("Instruction address = %h", w_iaddr_nxt);
            if (r_state == ST_RUN && w_state_nxt == ST_HALTED) $display("PC halted at %h", r_iaddr);
            if (w_set_ovf && !r_ovf) $display("RAS overflow at %h", r_iaddr);
            if (w_set_unf && !r_unf) $display("RAS underflow at %h", r_iaddr);
        end
    end
`else
`endif

    assign iaddr     = r_iaddr;
    assign halted    = (r_state == ST_HALTED);
    assign ras_empty = r_empty;
    assign ras_full  = r_full;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb/tb_pc_seq_unit.sv - scoreboard bench for pc_seq_unit
module tb_pc_seq_unit;

    localparam logic [6:0] I = 7'h00, R = 7'h40, S = 7'h20, H = 7'h10,
                           B = 7'h08, J = 7'h04, C = 7'h02, T = 7'h01;

    logic        clk = 1'b0;
    logic        rst, stall, hlt, br_taken, jmp, call, ret;
    logic [15:0] br_target, jmp_target;
    logic [15:0] iaddr;
    logic        halted, ras_empty, ras_full, ras_ovf, ras_unf;
    logic [20:0] obs;
    logic [20:0] ex;
    logic [20:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    pc_seq_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .hlt(hlt),
        .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .call(call), .jmp_target(jmp_target), .ret(ret),
        .iaddr(iaddr), .halted(halted), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    assign obs = {iaddr, halted, ras_empty, ras_full, ras_ovf, ras_unf};

    function automatic logic [20:0] e(input logic [15:0] a, input logic h, em, f, o, u);
        return {a, h, em, f, o, u};
    endfunction

    // Drive one cycle of stimulus, record its expected outcome, sample after the edge.
    task automatic apply(input logic [6:0] ctl, input logic [15:0] btg, jtg, input logic [20:0] x);
        {rst, stall, hlt, br_taken, jmp, call, ret} = ctl;
        br_target  = btg;
        jmp_target = jtg;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [6:0]  c [5];
        logic [20:0] x [5];
        c = '{R | J, I, I, I, I};
        x = '{e(16'h0000,0,1,0,0,0), e(16'h0001,0,1,0,0,0), e(16'h0002,0,1,0,0,0),
              e(16'h0003,0,1,0,0,0), e(16'h0004,0,1,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            apply(c[i], 16'h0000, 16'h7777, x[i]);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, obs, ex);
            end
        end
    endtask

    task automatic test_priority;
        logic [6:0]  c [6];
        logic [15:0] bt [6];
        logic [15:0] jt [6];
        logic [20:0] x [6];
        c  = '{J, B | J, B, C | J | B, T | C | J, I};
        bt = '{16'h0000, 16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000};
        jt = '{16'h0010, 16'h0080, 16'h0000, 16'h0090, 16'h0099, 16'h0000};
        x  = '{e(16'h0010,0,1,0,0,0), e(16'h0080,0,1,0,0,0), e(16'h0040,0,1,0,0,0),
               e(16'h0090,0,0,0,0,0), e(16'h0041,0,1,0,0,0), e(16'h0042,0,1,0,0,0)};
        for (int i = 0; i < 6; i++) begin
            apply(c[i], bt[i], jt[i], x[i]);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL priority[%0d] got=%h exp=%h", i, obs, ex);
            end
        end
    endtask

    task automatic test_ras;
        logic [6:0]  c [14];
        logic [15:0] jt [14];
        logic [20:0] x [14];
        c  = '{R, J, C, C, C, C, C, T, T, T, T, T, I, I};
        jt = '{16'h0000, 16'h0010, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        x  = '{e(16'h0000,0,1,0,0,0), e(16'h0010,0,1,0,0,0), e(16'h0100,0,0,0,0,0),
               e(16'h0200,0,0,0,0,0), e(16'h0300,0,0,0,0,0), e(16'h0400,0,0,1,0,0),
               e(16'h0500,0,0,1,1,0), e(16'h0301,0,0,0,1,0), e(16'h0201,0,0,0,1,0),
               e(16'h0101,0,0,0,1,0), e(16'h0011,0,1,0,1,0), e(16'h0012,0,1,0,1,1),
               e(16'h0013,0,1,0,1,1), e(16'h0014,0,1,0,1,1)};
        for (int i = 0; i < 14; i++) begin
            apply(c[i], 16'h0000, jt[i], x[i]);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL ras[%0d] got=%h exp=%h", i, obs, ex);
            end
        end
    endtask

    task automatic test_stall;
        logic [6:0]  c [7];
        logic [15:0] jt [7];
        logic [20:0] x [7];
        c  = '{R, J, S | C, S | T | J, C, T, S | H};
        jt = '{16'h0000, 16'h0020, 16'h0300, 16'h0300, 16'h0300, 16'h0000, 16'h0000};
        x  = '{e(16'h0000,0,1,0,0,0), e(16'h0020,0,1,0,0,0), e(16'h0020,0,1,0,0,0),
               e(16'h0020,0,1,0,0,0), e(16'h0300,0,0,0,0,0), e(16'h0021,0,1,0,0,0),
               e(16'h0021,0,1,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            apply(c[i], 16'h0000, jt[i], x[i]);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL stall[%0d] got=%h exp=%h", i, obs, ex);
            end
        end
        apply(R | S | J, 16'h0000, 16'h0abc, e(16'h0000,0,1,0,0,0));
        ex = exp_q.pop_front();
        n_cmp++;
        if (obs !== ex) begin
            n_err++;
            $display("FAIL stall_rst got=%h exp=%h", obs, ex);
        end
    endtask

    task automatic test_halt;
        logic [6:0]  c [5];
        logic [15:0] jt [5];
        logic [20:0] x [5];
        c  = '{R, J, C, S | H, H};
        jt = '{16'h0000, 16'h0004, 16'h0005, 16'h0000, 16'h0000};
        x  = '{e(16'h0000,0,1,0,0,0), e(16'h0004,0,1,0,0,0), e(16'h0005,0,0,0,0,0),
               e(16'h0005,0,0,0,0,0), e(16'h0005,1,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            apply(c[i], 16'h0000, jt[i], x[i]);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL halt[%0d] got=%h exp=%h", i, obs, ex);
            end
        end
        for (int i = 0; i < 10; i++) begin
            apply({1'b0, 6'($urandom)} | T, 16'($urandom), 16'($urandom), e(16'h0005,1,0,0,0,0));
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL halt_frozen[%0d] got=%h exp=%h", i, obs, ex);
            end
        end
        apply(R | J, 16'h0000, 16'h0055, e(16'h0000,0,1,0,0,0));
        apply(I, 16'h0000, 16'h0000, e(16'h0001,0,1,0,0,0));
        for (int i = 0; i < 2; i++) begin
            ex = exp_q.pop_front();
            n_cmp++;
            if (i == 0 && ex !== e(16'h0000,0,1,0,0,0)) begin
                n_err++;
                $display("FAIL halt_sb order got=%h exp=%h", ex, e(16'h0000,0,1,0,0,0));
            end
        end
        n_cmp++;
        if (obs !== ex) begin
            n_err++;
            $display("FAIL halt_exit got=%h exp=%h", obs, ex);
        end
    endtask

    task automatic test_wrap;
        logic [6:0]  c [6];
        logic [15:0] jt [6];
        logic [20:0] x [6];
        c  = '{R, J, I, J, C, T};
        jt = '{16'h0000, 16'hffff, 16'h0000, 16'hffff, 16'h1234, 16'h0000};
        x  = '{e(16'h0000,0,1,0,0,0), e(16'hffff,0,1,0,0,0), e(16'h0000,0,1,0,0,0),
               e(16'hffff,0,1,0,0,0), e(16'h1234,0,0,0,0,0), e(16'h0000,0,1,0,0,0)};
        for (int i = 0; i < 6; i++) begin
            apply(c[i], 16'h0000, jt[i], x[i]);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL wrap[%0d] got=%h exp=%h", i, obs, ex);
            end
        end
    endtask

    initial begin
        {rst, stall, hlt, br_taken, jmp, call, ret} = '0;
        br_target  = '0;
        jmp_target = '0;
        @(negedge clk);
        test_reset();
        test_priority();
        test_ras();
        test_stall();
        test_halt();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
